lsu: RTL and testbench
======================

// Module: lsu
// PURPOSE
//  Load/store unit: initiator side of the data-memory port. Accepts one load/store
//  per handshake from the execute stage and drives dmem addr/wdata/wmask/we.
//  Extracts and sign/zero-extends load data. Splits word-crossing accesses into two.
//  Sits between the datapath's memory stage and dmem.
// PARAMETERS
//  ALLOW_MISALIGNED  1  1: split word-crossing accesses; 0: flag resp_error, no access
//  (XLEN=32 comes from constants.vh, not a parameter)
// PORTS
//  clk          in   1     clock; all state updates on posedge
//  rst_n        in   1     reset, asynchronous, active-low
//  req_valid    in   1     request present
//  req_ready    out  1     LSU can accept (high only in IDLE)
//  req_we       in   1     1=store, 0=load
//  req_funct3   in   3     RV32I funct3: LB/LH/LW/LBU/LHU, SB/SH/SW
//  req_addr     in   XLEN  byte address
//  req_wdata    in   XLEN  store data, right-aligned
//  resp_valid   out  1     one-cycle pulse: access complete
//  resp_rdata   out  XLEN  extended load data (0 for stores/errors)
//  resp_error   out  1     illegal funct3, or misaligned with ALLOW_MISALIGNED=0
//  dmem_addr    out  XLEN  to dmem addr
//  dmem_wdata   out  XLEN  to dmem wdata (unshifted; dmem shifts by addr[1:0])
//  dmem_wmask   out  XLEN  unshifted mask: B=0x000000FF, H=0x0000FFFF, W=0xFFFFFFFF
//  dmem_we      out  1     store strobe, 1 cycle per word
//  dmem_rdata   in   XLEN  combinational read of word at dmem_addr
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, dmem_we=0.
//  dmem_* outputs derive combinationally from state + latched request; dmem_we drops
//  the moment rst_n falls.
//  FSM IDLE->FIRST->(SECOND)->RESP->IDLE:
//   IDLE: req_ready=1. On req_valid, latch we/funct3/addr/wdata.
//     Illegal funct3 (011, 110, 111 loads; >=011 stores), or crossing with
//     ALLOW_MISALIGNED=0: go to RESP with error=1, no dmem access.
//   FIRST: dmem_addr=addr, wdata, mask. Load: capture lo = dmem_rdata >> {addr[1:0],3'b0}.
//     Store: dmem_we=1. Go to SECOND if crossing, else RESP.
//   SECOND: dmem_addr = {addr[31:2]+1, 2'b00}; the +1 wraps at 0xFFFFFFFC.
//     k = 32 - 8*addr[1:0]; wdata>>k and mask>>k. Load: hi = dmem_rdata << k.
//     Store: dmem_we=1.
//   RESP: resp_valid=1 for exactly one cycle, then IDLE.
//     rdata = ext(lo|hi) by size/sign; 0 when store or error.
//  crossing = addr[1:0] + bytes(size) > 4. W at offset 1-3 or H at offset 3.
//    B never crosses. Aligned-but-unnatural H at offset 1 does not cross: one access.
//  Latency (accept edge to resp_valid): 2 cycles single, 3 split, 1 error.
//    Throughput: one request per 3/4 cycles.
//  resp_rdata/resp_error hold until the next RESP; they are only meaningful with resp_valid.
//  req_valid is ignored outside IDLE. Request fields need only be stable at the accept edge.
//  Reset mid-split-store may leave the first word written. Permitted; no rollback.
// STRUCTURE
//  constants.vh gains the F3_* funct3 localparams, LSU state encodings, and MASK_B/H/W.
//  One sub-module, lsu_align (combinational): {funct3, lo|hi} -> extended rdata.
//  Shared with any future AMO path.
//  Top holds the FSM, request latch, lo/hi capture registers, and the dmem mux.
// TESTING
//  Bench uses a behavioural dmem model: comb read, posedge write, same shift/mask semantics.
//  1 LW 0x100, mem[0x40]=0xDEADBEEF -> resp_valid 2 cycles after accept, rdata=0xDEADBEEF,
//    one dmem access.
//  2 LB 0x103 / LBU 0x103, same word -> 0xFFFFFFDE / 0x000000DE.
//    LH 0x102 -> 0xFFFFDEAD.
//  3 SB 0x101 wdata=0x12345677 -> mem[0x40]=0xDEAD77EF. One we pulse, dmem_wmask=0xFF.
//  4 SW 0x0FE wdata=0xAABBCCDD, mem[0x3F]=mem[0x40]=0 -> mem[0x3F]=0xCCDD0000,
//    mem[0x40]=0x0000AABB. Two we pulses; LW 0x0FE reads back 0xAABBCCDD in 3 cycles.
//  5 funct3=3'b011 load; ALLOW_MISALIGNED=0 with LW 0x101 -> resp_error=1 after 1 cycle,
//    dmem_we never high, rdata=0.
//  6 rst_n low during SECOND of split SW -> dmem_we low immediately, state IDLE,
//    req_ready=1. LW 0xFFFFFFFE splits with second dmem_addr=0x00000000.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - funct3 encodings for RV32I loads and stores
//   - unshifted byte/half/word write masks
//   - LSU FSM state encoding
//   - small helpers: access size in bytes, size mask, funct3 legality and
//     word-crossing detection
package lsu_pkg;

    localparam int XLEN = 32;

    // Load funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    // Store funct3
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [XLEN-1:0] MASK_B = 32'h0000_00FF;
    localparam logic [XLEN-1:0] MASK_H = 32'h0000_FFFF;
    localparam logic [XLEN-1:0] MASK_W = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_SECOND = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

    // funct3[1:0] carries the access size for every legal encoding.
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return MASK_B;
            2'b01:   return MASK_H;
            default: return MASK_W;
        endcase
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        else
            return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                   (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // True when the access spills past the end of its 32-bit word.
    function automatic logic crosses(input logic [1:0] off, input logic [1:0] sz);
        return ({2'b00, off} + {1'b0, size_bytes(sz)}) > 4'd4;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Load-data extender (combinational).
//   funct3 : load funct3, selects size and signedness
//   data   : right-aligned merged load data (lo | hi)
//   rdata  : sign/zero-extended result; 0 for non-load encodings
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] data,
    output logic [XLEN-1:0] rdata
);

    always_comb begin
        rdata = '0;
        case (funct3)
            F3_LB:   rdata = {{24{data[7]}}, data[7:0]};
            F3_LH:   rdata = {{16{data[15]}}, data[15:0]};
            F3_LW:   rdata = data;
            F3_LBU:  rdata = {24'h0, data[7:0]};
            F3_LHU:  rdata = {16'h0, data[15:0]};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit, initiator side of the data-memory port.
// Takes one load/store per handshake, drives the dmem port, splits
// word-crossing accesses into two word accesses and returns extended load
// data with a one-cycle resp_valid pulse.
//   clk, rst_n             : clock, asynchronous active-low reset
//   req_valid/req_ready    : request handshake (ready only while idle)
//   req_we/funct3/addr/wdata : request fields, sampled at the accept edge
//   resp_valid             : one-cycle completion pulse
//   resp_rdata/resp_error  : result, held until the next completion
//   dmem_addr/wdata/wmask/we : memory port (unshifted data and mask)
//   dmem_rdata             : combinational read of the word at dmem_addr
module lsu
    import lsu_pkg::*;
#(
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_error,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [XLEN-1:0] dmem_wmask,
    output logic            dmem_we,
    input  logic [XLEN-1:0] dmem_rdata
);

    lsu_state_e state_reg, state_next;

    logic            we_reg;
    logic [2:0]      f3_reg;
    logic [XLEN-1:0] addr_reg;
    logic [XLEN-1:0] wdata_reg;
    logic [XLEN-1:0] lo_reg;
    logic [XLEN-1:0] resp_rdata_reg, resp_rdata_next;
    logic            resp_error_reg, resp_error_next;
    logic            resp_load;

    logic [1:0]      off;
    logic [4:0]      lo_shift;
    logic [5:0]      hi_shift;
    logic [XLEN-1:0] lo_now;
    logic [XLEN-1:0] hi_now;
    logic [XLEN-1:0] merged;
    logic [XLEN-1:0] aligned;
    logic            cross_reg;
    logic            req_bad;
    logic            accept;

    assign accept    = (state_reg == ST_IDLE) && req_valid;
    assign req_ready = (state_reg == ST_IDLE);
    assign resp_valid = (state_reg == ST_RESP);
    assign resp_rdata = resp_rdata_reg;
    assign resp_error = resp_error_reg;

    // Rejected requests never touch dmem; the decision is made from the live
    // request fields so the error response can come one cycle after accept.
    assign req_bad = !f3_legal(req_we, req_funct3) ||
                     ((ALLOW_MISALIGNED == 0) && crosses(req_addr[1:0], req_funct3[1:0]));

    assign off       = addr_reg[1:0];
    assign cross_reg = crosses(off, f3_reg[1:0]);
    assign lo_shift  = {off, 3'b000};
    // Only used in SECOND, where off is never 0, so the shift is 8..24.
    assign hi_shift  = 6'd32 - {1'b0, off, 3'b000};
    assign lo_now    = dmem_rdata >> lo_shift;
    assign hi_now    = dmem_rdata << hi_shift;

    lsu_align u_align (
        .funct3 (f3_reg),
        .data   (merged),
        .rdata  (aligned)
    );

    // dmem port: purely from state + latched request, so dmem_we falls as
    // soon as the asynchronous reset forces the state back to IDLE.
    always_comb begin
        dmem_addr  = addr_reg;
        dmem_wdata = wdata_reg;
        dmem_wmask = size_mask(f3_reg[1:0]);
        dmem_we    = 1'b0;
        case (state_reg)
            ST_FIRST: begin
                dmem_we = we_reg;
            end
            ST_SECOND: begin
                // Upper part of the access lands at offset 0 of the next word;
                // the word index wraps naturally at the top of the address space.
                dmem_addr  = {addr_reg[31:2] + 30'd1, 2'b00};
                dmem_wdata = wdata_reg >> hi_shift;
                dmem_wmask = size_mask(f3_reg[1:0]) >> hi_shift;
                dmem_we    = we_reg;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        merged          = '0;
        resp_load       = 1'b0;
        resp_error_next = 1'b0;
        resp_rdata_next = '0;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_bad) begin
                        state_next      = ST_RESP;
                        resp_load       = 1'b1;
                        resp_error_next = 1'b1;
                    end else begin
                        state_next = ST_FIRST;
                    end
                end
            end
            ST_FIRST: begin
                if (cross_reg) begin
                    state_next = ST_SECOND;
                end else begin
                    state_next      = ST_RESP;
                    resp_load       = 1'b1;
                    merged          = lo_now;
                    resp_rdata_next = we_reg ? '0 : aligned;
                end
            end
            ST_SECOND: begin
                state_next      = ST_RESP;
                resp_load       = 1'b1;
                merged          = lo_reg | hi_now;
                resp_rdata_next = we_reg ? '0 : aligned;
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            we_reg         <= 1'b0;
            f3_reg         <= '0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            lo_reg         <= '0;
            resp_rdata_reg <= '0;
            resp_error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                we_reg    <= req_we;
                f3_reg    <= req_funct3;
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
            end
            if (state_reg == ST_FIRST)
                lo_reg <= lo_now;
            if (resp_load) begin
                resp_rdata_reg <= resp_rdata_next;
                resp_error_reg <= resp_error_next;
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: dut_a (misaligned accesses split) runs against a
// behavioural word memory; dut_b (misaligned accesses rejected) sees a fixed
// read word. Stimulus pushes expected responses; monitors pop and compare.
module tb_lsu;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // dut_a signals
    logic        a_req_valid, a_req_ready, a_req_we;
    logic [2:0]  a_req_funct3;
    logic [31:0] a_req_addr, a_req_wdata;
    logic        a_resp_valid, a_resp_error;
    logic [31:0] a_resp_rdata;
    logic [31:0] a_dmem_addr, a_dmem_wdata, a_dmem_wmask, a_dmem_rdata;
    logic        a_dmem_we;
    // dut_b signals
    logic        b_req_valid, b_req_ready, b_req_we;
    logic [2:0]  b_req_funct3;
    logic [31:0] b_req_addr, b_req_wdata;
    logic        b_resp_valid, b_resp_error;
    logic [31:0] b_resp_rdata;
    logic [31:0] b_dmem_addr, b_dmem_wdata, b_dmem_wmask, b_dmem_rdata;
    logic        b_dmem_we;

    lsu #(.ALLOW_MISALIGNED(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_funct3(a_req_funct3), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_error(a_resp_error),
        .dmem_addr(a_dmem_addr), .dmem_wdata(a_dmem_wdata), .dmem_wmask(a_dmem_wmask),
        .dmem_we(a_dmem_we), .dmem_rdata(a_dmem_rdata)
    );

    lsu #(.ALLOW_MISALIGNED(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_error(b_resp_error),
        .dmem_addr(b_dmem_addr), .dmem_wdata(b_dmem_wdata), .dmem_wmask(b_dmem_wmask),
        .dmem_we(b_dmem_we), .dmem_rdata(b_dmem_rdata)
    );

    assign b_dmem_rdata = 32'hCAFE_F00D;

    // Behavioural dmem: comb read, posedge write shifted by addr[1:0].
    // Backdoor preloads go through the same process.
    logic [31:0] mem [0:255];
    logic        bd_en = 1'b0;
    logic [7:0]  bd_idx = '0;
    logic [31:0] bd_val = '0;
    logic [4:0]  wsh;
    logic [31:0] wm;
    assign a_dmem_rdata = mem[a_dmem_addr[9:2]];
    always @(posedge clk) begin
        if (bd_en) mem[bd_idx] = bd_val;
        if (a_dmem_we) begin
            wsh = {a_dmem_addr[1:0], 3'b000};
            wm  = a_dmem_wmask << wsh;
            mem[a_dmem_addr[9:2]] = (mem[a_dmem_addr[9:2]] & ~wm) | ((a_dmem_wdata << wsh) & wm);
        end
    end

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] acc_q[$];
    int          we_cnt = 0;
    int          b_we_seen = 0;
    logic [31:0] last_mask = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors
    always @(negedge clk) begin
        exp_t e;
        if (a_resp_valid) begin
            if (qa.size() == 0) begin
                check("a_unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = qa.pop_front();
                check("a_rdata", a_resp_rdata, e.rdata);
                check("a_error", {31'b0, a_resp_error}, {31'b0, e.err});
                check("a_latency", cyc - e.acc + 1, e.lat);
                $display("A resp rdata=%h err=%b lat=%0d", a_resp_rdata, a_resp_error, cyc - e.acc + 1);
            end
        end
        if (rst_n && !a_req_ready && !a_resp_valid) acc_q.push_back(a_dmem_addr);
        if (a_dmem_we) begin
            we_cnt++;
            last_mask = a_dmem_wmask;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b_resp_valid) begin
            if (qb.size() == 0) begin
                check("b_unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = qb.pop_front();
                check("b_rdata", b_resp_rdata, e.rdata);
                check("b_error", {31'b0, b_resp_error}, {31'b0, e.err});
                check("b_latency", cyc - e.acc + 1, e.lat);
                $display("B resp rdata=%h err=%b lat=%0d", b_resp_rdata, b_resp_error, cyc - e.acc + 1);
            end
        end
        if (b_dmem_we) b_we_seen++;
    end

    task automatic poke(input logic [7:0] idx, input logic [31:0] val);
        @(negedge clk);
        bd_en = 1'b1; bd_idx = idx; bd_val = val;
        @(negedge clk);
        bd_en = 1'b0;
    endtask

    task automatic issue(input bit sel, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] er, input logic ee, input int lat);
        exp_t e;
        int guard = 0;
        @(negedge clk);
        while (!(sel ? b_req_ready : a_req_ready) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            check("issue_ready_timeout", 32'd0, 32'd1);
            return;
        end
        e.rdata = er; e.err = ee; e.acc = cyc + 1; e.lat = lat;
        if (sel) begin
            b_req_valid = 1'b1; b_req_we = we; b_req_funct3 = f3; b_req_addr = addr; b_req_wdata = wdata;
            qb.push_back(e);
        end else begin
            a_req_valid = 1'b1; a_req_we = we; a_req_funct3 = f3; a_req_addr = addr; a_req_wdata = wdata;
            qa.push_back(e);
        end
        $display("%s issue we=%b f3=%b addr=%h wdata=%h", sel ? "B" : "A", we, f3, addr, wdata);
        @(negedge clk);
        if (sel) b_req_valid = 1'b0; else a_req_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((qa.size() != 0 || qb.size() != 0 || !a_req_ready || !b_req_ready) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("drain_timeout", 32'd0, 32'd1);
    endtask

    int we0;

    initial begin
        a_req_valid = 0; a_req_we = 0; a_req_funct3 = 0; a_req_addr = 0; a_req_wdata = 0;
        b_req_valid = 0; b_req_we = 0; b_req_funct3 = 0; b_req_addr = 0; b_req_wdata = 0;
        #2 rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst_req_ready", {31'b0, a_req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, a_resp_valid}, 32'd0);
        check("rst_resp_rdata", a_resp_rdata, 32'd0);
        check("rst_resp_error", {31'b0, a_resp_error}, 32'd0);
        check("rst_dmem_we", {31'b0, a_dmem_we}, 32'd0);
        rst_n = 1'b1;

        // 1: aligned LW, single access
        poke(8'h40, 32'hDEAD_BEEF);
        acc_q.delete();
        issue(0, 0, 3'b010, 32'h100, 0, 32'hDEAD_BEEF, 0, 2);
        drain();
        check("lw_access_count", acc_q.size(), 32'd1);
        if (acc_q.size() > 0) check("lw_access_addr", acc_q[0], 32'h100);

        // 2: byte/half extraction and extension
        issue(0, 0, 3'b000, 32'h103, 0, 32'hFFFF_FFDE, 0, 2);
        issue(0, 0, 3'b100, 32'h103, 0, 32'h0000_00DE, 0, 2);
        issue(0, 0, 3'b001, 32'h102, 0, 32'hFFFF_DEAD, 0, 2);
        issue(0, 0, 3'b101, 32'h101, 0, 32'h0000_ADBE, 0, 2);
        drain();

        // 3: SB
        we0 = we_cnt;
        issue(0, 1, 3'b000, 32'h101, 32'h1234_5677, 32'h0, 0, 2);
        drain();
        check("sb_mem", mem[8'h40], 32'hDEAD_77EF);
        check("sb_we_pulses", we_cnt - we0, 32'd1);
        check("sb_wmask", last_mask, 32'h0000_00FF);

        // 4: split SW and split loads
        poke(8'h3F, 32'h0); poke(8'h40, 32'h0);
        we0 = we_cnt;
        issue(0, 1, 3'b010, 32'h0FE, 32'hAABB_CCDD, 32'h0, 0, 3);
        drain();
        check("sw_split_lo", mem[8'h3F], 32'hCCDD_0000);
        check("sw_split_hi", mem[8'h40], 32'h0000_AABB);
        check("sw_we_pulses", we_cnt - we0, 32'd2);
        issue(0, 0, 3'b010, 32'h0FE, 0, 32'hAABB_CCDD, 0, 3);
        issue(0, 0, 3'b001, 32'h0FF, 0, 32'hFFFF_BBCC, 0, 3);
        drain();

        // 5: errors
        issue(0, 0, 3'b011, 32'h100, 0, 32'h0, 1, 1);
        issue(0, 1, 3'b011, 32'h100, 32'hFFFF_FFFF, 32'h0, 1, 1);
        issue(1, 0, 3'b010, 32'h101, 0, 32'h0, 1, 1);
        issue(1, 1, 3'b001, 32'h103, 32'h1234_5678, 32'h0, 1, 1);
        issue(1, 0, 3'b010, 32'h100, 0, 32'hCAFE_F00D, 0, 2);
        drain();
        check("b_we_never", b_we_seen, 32'd0);

        // 6: reset during the second half of a split store
        poke(8'h3F, 32'h0); poke(8'h40, 32'h1111_1111);
        @(negedge clk);
        a_req_valid = 1; a_req_we = 1; a_req_funct3 = 3'b010; a_req_addr = 32'h0FE; a_req_wdata = 32'hAABB_CCDD;
        @(negedge clk);
        a_req_valid = 0;
        @(negedge clk);
        check("mid_split_we_high", {31'b0, a_dmem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_we", {31'b0, a_dmem_we}, 32'd0);
        check("rst_async_ready", {31'b0, a_req_ready}, 32'd1);
        check("rst_async_valid", {31'b0, a_resp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_no_second_write", mem[8'h40], 32'h1111_1111);

        // wrap of the second word address
        poke(8'hFF, 32'hBEEF_0000); poke(8'h00, 32'h0000_CAFE);
        acc_q.delete();
        issue(0, 0, 3'b010, 32'hFFFF_FFFE, 0, 32'hCAFE_BEEF, 0, 3);
        drain();
        check("wrap_access_count", acc_q.size(), 32'd2);
        if (acc_q.size() == 2) begin
            check("wrap_first_addr", acc_q[0], 32'hFFFF_FFFE);
            check("wrap_second_addr", acc_q[1], 32'h0000_0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
